// File: rtl/blink_period_meter.sv
// blink_period_meter: measures the period of an asynchronous blink/toggle line.
// A rising edge is synchronized, the cycles between consecutive rising edges are
// counted and reported, each period is checked against EXPECTED +/- TOL, a timeout
// is raised when edges stop arriving, and lock is declared after two good periods.
module blink_period_meter #(
    parameter int unsigned WIDTH    = 26,
    parameter int unsigned EXPECTED = 50_000_000,
    parameter int unsigned TOL      = 500,
    parameter int unsigned TIMEOUT  = 60_000_000
) (
    input  logic             CLOCK_50,
    input  logic             KEY,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             in_tol,
    output logic             timeout,
    output logic             locked
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALLED = 2'd2
    } state_t;

    // Tolerance window; the lower bound clamps at zero instead of wrapping.
    // The window is held one bit wider than any 32-bit sum so EXPECTED+TOL cannot wrap.
    localparam logic [32:0] LO_BOUND = (TOL > EXPECTED) ? 33'd0 : 33'(EXPECTED - TOL);
    localparam logic [32:0] HI_BOUND = 33'(EXPECTED) + 33'(TOL);
    localparam logic [WIDTH-1:0] TO_CNT  = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic             s1, s2, s3;
    logic             rise;
    logic [WIDTH-1:0] cnt;
    logic             cnt_ok;
    logic [1:0]       run;
    state_t           state;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge CLOCK_50 or posedge KEY) begin
        if (KEY) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise   = s2 & ~s3;
    assign cnt_ok = (33'(cnt) >= LO_BOUND) && (33'(cnt) <= HI_BOUND);

    // Period measurement FSM; every output is a register updated here.
    always_ff @(posedge CLOCK_50 or posedge KEY) begin
        if (KEY) begin
            state   <= IDLE;
            cnt     <= '0;
            period  <= '0;
            valid   <= 1'b0;
            in_tol  <= 1'b0;
            timeout <= 1'b0;
            run     <= 2'd0;
            locked  <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    // First edge only starts the count: there is no reference yet.
                    if (rise) begin
                        state <= MEASURE;
                        cnt   <= CNT_ONE;
                    end
                end
                MEASURE: begin
                    // A rise on the same cycle cnt reaches TIMEOUT still counts as a period.
                    if (rise) begin
                        period <= cnt;
                        valid  <= 1'b1;
                        in_tol <= cnt_ok;
                        cnt    <= CNT_ONE;
                        if (cnt_ok) begin
                            run    <= (run == 2'd2) ? 2'd2 : run + 2'd1;
                            locked <= (run != 2'd0);
                        end else begin
                            run    <= 2'd0;
                            locked <= 1'b0;
                        end
                    end else if (cnt == TO_CNT) begin
                        state   <= STALLED;
                        timeout <= 1'b1;
                        run     <= 2'd0;
                        locked  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STALLED: begin
                    // The edge ending a stall bounds a partial period, so no valid.
                    if (rise) begin
                        state   <= MEASURE;
                        cnt     <= CNT_ONE;
                        timeout <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
